// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter and its port interface.
// The grant FSM state and the word and byte-mask widths are defined here.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// Bundle of the fetch port, the memory-stage port and the physical memory port around the arbiter.
// slave is the arbiter's view. master is the view of the stages and the memory.
interface lc3b_mem_arbiter_if;
  import lc3b_types::*;

  logic          i_read;
  lc3b_word      i_address;
  lc3b_word      i_rdata;
  logic          i_resp;

  logic          d_read;
  logic          d_write;
  lc3b_mem_wmask d_wmask;
  lc3b_word      d_address;
  lc3b_word      d_wdata;
  lc3b_word      d_rdata;
  logic          d_resp;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_mem_wmask pmem_wmask;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_wmask, d_address, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_wmask, d_address, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Shares one physical memory port between instruction fetch and the memory stage.
// The data port has priority, and a bounded streak counter makes sure fetch is eventually served.
module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lc3b_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  lc3b_arb_state r_state;
  logic [3:0]    r_dStreak;
  logic          r_pmemRead;
  logic          r_pmemWrite;
  lc3b_mem_wmask r_pmemWmask;
  lc3b_word      r_pmemAddress;
  lc3b_word      r_pmemWdata;

  logic w_iReq;
  logic w_dReq;
  logic w_grantI;
  logic w_iResp;
  logic w_dResp;

  assign w_iReq   = bus.i_read;
  assign w_dReq   = bus.d_read | bus.d_write;
  assign w_grantI = w_iReq & (~w_dReq | (r_dStreak == LIMIT));

  // A simultaneous read and write request is illegal and is served as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_dStreak     <= '0;
      r_pmemRead    <= 1'b0;
      r_pmemWrite   <= 1'b0;
      r_pmemWmask   <= '0;
      r_pmemAddress <= '0;
      r_pmemWdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grantI) begin
            r_state       <= SERVE_I;
            r_pmemRead    <= 1'b1;
            r_pmemWrite   <= 1'b0;
            r_pmemAddress <= bus.i_address;
            r_pmemWdata   <= '0;
            r_pmemWmask   <= '0;
            r_dStreak     <= '0;
          end else if (w_dReq) begin
            r_state       <= SERVE_D;
            r_pmemRead    <= ~bus.d_write;
            r_pmemWrite   <= bus.d_write;
            r_pmemAddress <= bus.d_address;
            r_pmemWdata   <= bus.d_wdata;
            r_pmemWmask   <= bus.d_wmask;
            if (!w_iReq) begin
              r_dStreak <= '0;
            end else if (r_dStreak != LIMIT) begin
              r_dStreak <= r_dStreak + 4'd1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            r_pmemRead  <= 1'b0;
            r_pmemWrite <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_iResp = (r_state == SERVE_I) & bus.pmem_resp;
  assign w_dResp = (r_state == SERVE_D) & bus.pmem_resp;

  assign bus.i_resp  = w_iResp;
  assign bus.d_resp  = w_dResp;
  assign bus.i_rdata = w_iResp ? bus.pmem_rdata : '0;
  assign bus.d_rdata = w_dResp ? bus.pmem_rdata : '0;

  assign bus.pmem_read    = r_pmemRead;
  assign bus.pmem_write   = r_pmemWrite;
  assign bus.pmem_wmask   = r_pmemWmask;
  assign bus.pmem_address = r_pmemAddress;
  assign bus.pmem_wdata   = r_pmemWdata;

endmodule
